// File: rtl/rst_sequencer_pkg.sv
// Shared state encoding and counter sizing for the reset sequencer.
package rst_sequencer_pkg;

    typedef enum logic [2:0] {
        S_RESET     = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_HOLD_BUS  = 3'd2,
        S_HOLD_CORE = 3'd3,
        S_RUN       = 3'd4
    } state_t;

    // Width large enough to hold the largest of the three cycle counts.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/rst_sync_ff.sv
// Two-flop synchronizer with asynchronous active-low clear.
module rst_sync_ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/rst_sequencer.sv
// Bus/core reset sequencer gated by DCM lock and a board push-button.
// RST_SEQUENCER_DEBOUNCE_EN selects a debounced button; otherwise a synchronized rising edge is used.
//
// state       | meaning
// S_RESET     | just out of power-on reset
// S_WAIT_LOCK | both resets asserted, waiting for synchronized lock
// S_HOLD_BUS  | lock seen, counting the bus hold period
// S_HOLD_CORE | bus released, counting the core release delay
// S_RUN       | both resets released, ready
module rst_sequencer #(
    parameter int HOLD_CYCLES     = 16,
    parameter int CORE_DELAY      = 4,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic dcm_locked_i,
    input  logic button_i,
    output logic rst_bus_o,
    output logic rst_core_o,
    output logic ready_o
);

    import rst_sequencer_pkg::*;

    localparam int CW = cnt_width(HOLD_CYCLES, CORE_DELAY, DEBOUNCE_CYCLES);

    logic          lock_s;
    logic          btn_s;
    logic          btn_accept;
    logic [CW-1:0] cnt;
    state_t        state;

    rst_sync_ff u_sync_lock (
        .clk   (clk_i),
        .rst_n (rst_n_i),
        .d     (dcm_locked_i),
        .q     (lock_s)
    );

    rst_sync_ff u_sync_btn (
        .clk   (clk_i),
        .rst_n (rst_n_i),
        .d     (button_i),
        .q     (btn_s)
    );

`ifdef RST_SEQUENCER_DEBOUNCE_EN
    logic [CW-1:0] deb_cnt;

    // Saturates at DEBOUNCE_CYCLES so a held button accepts exactly once.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            deb_cnt <= '0;
        end else if (!btn_s) begin
            deb_cnt <= '0;
        end else if (deb_cnt != CW'(DEBOUNCE_CYCLES)) begin
            deb_cnt <= deb_cnt + 1'b1;
        end
    end

    assign btn_accept = btn_s && (deb_cnt == CW'(DEBOUNCE_CYCLES - 1));
`else
    logic btn_s_d;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            btn_s_d <= 1'b0;
        end else begin
            btn_s_d <= btn_s;
        end
    end

    assign btn_accept = btn_s & ~btn_s_d;
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state      <= S_RESET;
            cnt        <= '0;
            rst_bus_o  <= 1'b1;
            rst_core_o <= 1'b1;
            ready_o    <= 1'b0;
        end else begin
            unique case (state)
                S_RESET: begin
                    state <= S_WAIT_LOCK;
                end
                S_WAIT_LOCK: begin
                    rst_bus_o  <= 1'b1;
                    rst_core_o <= 1'b1;
                    ready_o    <= 1'b0;
                    if (lock_s) begin
                        cnt   <= CW'(HOLD_CYCLES - 1);
                        state <= S_HOLD_BUS;
                    end
                end
                S_HOLD_BUS: begin
                    if (!lock_s) begin
                        state <= S_WAIT_LOCK;
                    end else if (cnt == '0) begin
                        rst_bus_o <= 1'b0;
                        cnt       <= CW'(CORE_DELAY - 1);
                        state     <= S_HOLD_CORE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_HOLD_CORE: begin
                    if (!lock_s) begin
                        rst_bus_o <= 1'b1;
                        state     <= S_WAIT_LOCK;
                    end else if (cnt == '0) begin
                        rst_core_o <= 1'b0;
                        ready_o    <= 1'b1;
                        state      <= S_RUN;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_RUN: begin
                    // Lock loss and button in the same cycle collapse into one re-entry.
                    if (!lock_s || btn_accept) begin
                        rst_bus_o  <= 1'b1;
                        rst_core_o <= 1'b1;
                        ready_o    <= 1'b0;
                        state      <= S_WAIT_LOCK;
                    end
                end
                default: begin
                    rst_bus_o  <= 1'b1;
                    rst_core_o <= 1'b1;
                    ready_o    <= 1'b0;
                    state      <= S_RESET;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rst_sequencer.sv
// Scoreboard bench for rst_sequencer: expected output events {cycle, bus, core, ready} are queued
// by the stimulus and matched by a monitor whenever the outputs change.
module tb_rst_sequencer;

    logic clk = 1'b0;
    logic rst_n;
    logic dcm_locked;
    logic button;
    logic rst_bus;
    logic rst_core;
    logic ready;
    logic [2:0] outs;

    int cyc      = 0;
    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int         edge_n;
        logic [2:0] val;
    } exp_t;

    exp_t exp_q[$];

    rst_sequencer #(
        .HOLD_CYCLES     (16),
        .CORE_DELAY      (4),
        .DEBOUNCE_CYCLES (8)
    ) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .dcm_locked_i (dcm_locked),
        .button_i     (button),
        .rst_bus_o    (rst_bus),
        .rst_core_o   (rst_core),
        .ready_o      (ready)
    );

    assign outs = {rst_bus, rst_core, ready};

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Park on the falling edge just before posedge number e, so a change made now is sampled at e.
    task automatic goto(input int e);
        while (cyc < e - 1) @(negedge clk);
    endtask

    task automatic expect_at(input int e, input logic [2:0] v);
        exp_t x;
        x.edge_n = e;
        x.val    = v;
        exp_q.push_back(x);
    endtask

    task automatic check_now(input string name, input logic [2:0] req);
        n_checks++;
        if (outs !== req) begin
            n_fail++;
            $display("FAIL %s: cycle %0d outputs %b, required %b", name, cyc, outs, req);
        end
    endtask

    initial begin
        rst_n      = 1'b1;
        dcm_locked = 1'b0;
        button     = 1'b0;
        fork
            begin : stimulus
                #1 rst_n = 1'b0;
                goto(6);
                check_now("reset_state", 3'b110);
                rst_n = 1'b1;
                goto(26);
                check_now("no_lock_hold", 3'b110);

                // First lock: bus at N+18, core/ready at N+22
                goto(30);
                expect_at(48, 3'b010);
                expect_at(52, 3'b001);
                dcm_locked = 1'b1;

                // Lock loss in RUN, driven after edge 60
                goto(61);
                expect_at(63, 3'b110);
                dcm_locked = 1'b0;

                // Lock glitch during the hold restarts the full hold
                goto(70);
                dcm_locked = 1'b1;
                goto(81);
                dcm_locked = 1'b0;
                goto(90);
                expect_at(108, 3'b010);
                expect_at(112, 3'b001);
                dcm_locked = 1'b1;

`ifdef RST_SEQUENCER_DEBOUNCE_EN
                goto(120);
                button = 1'b1;
                goto(125);
                button = 1'b0;

                goto(130);
                expect_at(139, 3'b110);
                expect_at(156, 3'b010);
                expect_at(160, 3'b001);
                button = 1'b1;
                goto(142);
                button = 1'b0;

                goto(170);
                expect_at(179, 3'b110);
                expect_at(196, 3'b010);
                expect_at(200, 3'b001);
                button = 1'b1;
                goto(202);
                button = 1'b0;
                goto(204);
                button = 1'b1;
`else
                goto(120);
                expect_at(122, 3'b110);
                expect_at(139, 3'b010);
                expect_at(143, 3'b001);
                button = 1'b1;
                goto(125);
                button = 1'b0;

                // Long hold: one acceptance only
                goto(150);
                expect_at(152, 3'b110);
                expect_at(169, 3'b010);
                expect_at(173, 3'b001);
                button = 1'b1;
                goto(200);
                button = 1'b0;
                goto(211);
                button = 1'b1;
`endif
                // Button acceptance and lock loss land on the same edge
                goto(211);
                expect_at(213, 3'b110);
                dcm_locked = 1'b0;
                goto(216);
                button = 1'b0;

                goto(220);
                expect_at(238, 3'b010);
                dcm_locked = 1'b1;

                // Asynchronous reset mid S_HOLD_CORE
                goto(240);
                @(posedge clk);
                #2;
                expect_at(240, 3'b110);
                rst_n = 1'b0;
                #1 check_now("async_reset", 3'b110);
                goto(244);
                expect_at(262, 3'b010);
                expect_at(266, 3'b001);
                rst_n = 1'b1;

                goto(280);
                n_checks++;
                if (exp_q.size() != 0) begin
                    n_fail++;
                    $display("FAIL pending_events: %0d expected events never seen, required 0 (next at cycle %0d)",
                             exp_q.size(), exp_q[0].edge_n);
                end
            end
            begin : monitor
                logic [2:0] prev;
                exp_t       e;
                prev = 3'b110;
                forever begin
                    @(negedge clk);
                    if (outs !== prev) begin
                        n_checks++;
                        if (exp_q.size() == 0) begin
                            n_fail++;
                            $display("FAIL unexpected_change: cycle %0d outputs %b, required no change from %b",
                                     cyc, outs, prev);
                        end else begin
                            e = exp_q.pop_front();
                            if (e.edge_n != cyc || e.val !== outs) begin
                                n_fail++;
                                $display("FAIL output_event: cycle %0d outputs %b, required cycle %0d outputs %b",
                                         cyc, outs, e.edge_n, e.val);
                            end
                        end
                        prev = outs;
                    end
                end
            end
        join_any
        disable fork;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
